// File: rtl/run_monitor.sv
// ---------------------------------------------------------------------------
// run_monitor
//   Tracks one program run: counts cycles and retired instructions from start
//   until a halt has drained (or the watchdog trips). After that it parks in
//   DONE with frozen statistics until reset.
//
//   State table
//     IDLE  | waiting for start, counters held at 0
//     RUN   | counting cycles and retires, watching for halt
//     DRAIN | halt seen, letting in-flight instructions retire
//     DONE  | statistics frozen, o_stat_control high
//
// Ports
//   i_clk                  system clock, rising edge
//   i_rst                  asynchronous active-high reset
//   i_start                level, starts a run while in IDLE
//   i_retire               one instruction retired this cycle
//   i_halt                 halt instruction decoded this cycle
//   o_number_instructions  retired-instruction count (saturating)
//   o_number_cycles        cycles spent in RUN and DRAIN (saturating)
//   o_stat_control         high while in DONE
//   o_timeout              run ended by the watchdog rather than by halt
//   o_running              high in RUN or DRAIN
// ---------------------------------------------------------------------------
module run_monitor #(
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned DRAIN_CYCLES = 4,
  parameter logic [31:0] MAX_CYCLES   = 32'hFFFF_FFFF
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_retire,
  input  logic             i_halt,
  output logic [WIDTH-1:0] o_number_instructions,
  output logic [WIDTH-1:0] o_number_cycles,
  output logic             o_stat_control,
  output logic             o_timeout,
  output logic             o_running
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // Watchdog compares in 64 bits so any WIDTH / MAX_CYCLES pairing works;
  // a limit beyond the counter range simply never fires.
  localparam logic [63:0] LIMIT_M1   = {32'd0, MAX_CYCLES} - 64'd1;
  localparam logic [7:0]  DRAIN_LOAD = 8'(DRAIN_CYCLES - 1);

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_instr;
  logic [WIDTH-1:0] r_cycles;
  logic [7:0]       r_drain;
  logic             r_stat_control;
  logic             r_timeout;
  logic             r_running;

  logic [1:0]  w_next_state;
  logic [63:0] w_cycles_ext;
  logic        w_cycles_sat;
  logic        w_instr_sat;
  logic        w_at_limit;
  logic        w_wdog;

  assign w_cycles_ext = 64'(r_cycles);
  assign w_cycles_sat = &r_cycles;
  assign w_instr_sat  = &r_instr;
  // Only trips when the count would actually advance past the limit.
  assign w_at_limit   = (w_cycles_ext == LIMIT_M1) && !w_cycles_sat;

  always_comb begin
    w_next_state = r_state;
    w_wdog       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) w_next_state = S_RUN;
      end
      S_RUN: begin
        if (w_at_limit) begin
          w_wdog       = 1'b1;
          w_next_state = S_DONE;
        end else if (i_halt) begin
          w_next_state = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (w_at_limit) begin
          w_wdog       = 1'b1;
          w_next_state = S_DONE;
        end else if (r_drain == 8'd0) begin
          w_next_state = S_DONE;
        end
      end
      default: w_next_state = S_DONE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state        <= S_IDLE;
      r_instr        <= '0;
      r_cycles       <= '0;
      r_drain        <= 8'd0;
      r_stat_control <= 1'b0;
      r_timeout      <= 1'b0;
      r_running      <= 1'b0;
    end else begin
      r_state        <= w_next_state;
      r_running      <= (w_next_state == S_RUN) || (w_next_state == S_DRAIN);
      r_stat_control <= (w_next_state == S_DONE);
      if (w_wdog) r_timeout <= 1'b1;

      case (r_state)
        S_IDLE: begin
          r_instr  <= '0;
          r_cycles <= '0;
          r_drain  <= 8'd0;
        end
        S_RUN, S_DRAIN: begin
          if (!w_cycles_sat)           r_cycles <= r_cycles + 1'b1;
          if (i_retire && !w_instr_sat) r_instr  <= r_instr + 1'b1;
          if (r_state == S_RUN) begin
            if (i_halt && !w_at_limit) r_drain <= DRAIN_LOAD;
          end else if (r_drain != 8'd0) begin
            r_drain <= r_drain - 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_number_instructions = r_instr;
  assign o_number_cycles       = r_cycles;
  assign o_stat_control        = r_stat_control;
  assign o_timeout             = r_timeout;
  assign o_running             = r_running;

endmodule

// File: tb/tb_run_monitor.sv
// ---------------------------------------------------------------------------
// tb_run_monitor
//   Directed bench for run_monitor. Three instances cover the default build,
//   a short watchdog (MAX_CYCLES=20) and a narrow counter (WIDTH=4).
//   Inputs change just after the falling edge; outputs are checked on the
//   following falling edge, half a clock away from the active edge.
// ---------------------------------------------------------------------------
module tb_run_monitor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // instance A: defaults
  logic        a_rst, a_start, a_retire, a_halt;
  logic [31:0] a_instr, a_cycles;
  logic        a_stat, a_timeout, a_running;
  // instance B: MAX_CYCLES = 20
  logic        b_rst, b_start, b_retire, b_halt;
  logic [31:0] b_instr, b_cycles;
  logic        b_stat, b_timeout, b_running;
  // instance C: WIDTH = 4
  logic        c_rst, c_start, c_retire, c_halt;
  logic [3:0]  c_instr, c_cycles;
  logic        c_stat, c_timeout, c_running;

  run_monitor #(.WIDTH(32), .DRAIN_CYCLES(4), .MAX_CYCLES(32'hFFFF_FFFF)) dut_a (
    .i_clk(clk), .i_rst(a_rst), .i_start(a_start), .i_retire(a_retire), .i_halt(a_halt),
    .o_number_instructions(a_instr), .o_number_cycles(a_cycles),
    .o_stat_control(a_stat), .o_timeout(a_timeout), .o_running(a_running));

  run_monitor #(.WIDTH(32), .DRAIN_CYCLES(4), .MAX_CYCLES(32'd20)) dut_b (
    .i_clk(clk), .i_rst(b_rst), .i_start(b_start), .i_retire(b_retire), .i_halt(b_halt),
    .o_number_instructions(b_instr), .o_number_cycles(b_cycles),
    .o_stat_control(b_stat), .o_timeout(b_timeout), .o_running(b_running));

  run_monitor #(.WIDTH(4), .DRAIN_CYCLES(4), .MAX_CYCLES(32'hFFFF_FFFF)) dut_c (
    .i_clk(clk), .i_rst(c_rst), .i_start(c_start), .i_retire(c_retire), .i_halt(c_halt),
    .o_number_instructions(c_instr), .o_number_cycles(c_cycles),
    .o_stat_control(c_stat), .o_timeout(c_timeout), .o_running(c_running));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_a(input string tag, input logic [31:0] ins, input logic [31:0] cyc,
                       input logic st, input logic to, input logic rn);
    chk({tag, ".instr"},   a_instr,   ins);
    chk({tag, ".cycles"},  a_cycles,  cyc);
    chk({tag, ".stat"},    32'(a_stat),    32'(st));
    chk({tag, ".timeout"}, 32'(a_timeout), 32'(to));
    chk({tag, ".running"}, 32'(a_running), 32'(rn));
  endtask

  task automatic chk_b(input string tag, input logic [31:0] ins, input logic [31:0] cyc,
                       input logic st, input logic to, input logic rn);
    chk({tag, ".instr"},   b_instr,   ins);
    chk({tag, ".cycles"},  b_cycles,  cyc);
    chk({tag, ".stat"},    32'(b_stat),    32'(st));
    chk({tag, ".timeout"}, 32'(b_timeout), 32'(to));
    chk({tag, ".running"}, 32'(b_running), 32'(rn));
  endtask

  initial begin
    a_rst = 1'b1; a_start = 1'b0; a_retire = 1'b0; a_halt = 1'b0;
    b_rst = 1'b1; b_start = 1'b0; b_retire = 1'b0; b_halt = 1'b0;
    c_rst = 1'b1; c_start = 1'b0; c_retire = 1'b0; c_halt = 1'b0;

    @(negedge clk);
    chk_a("a_reset", 0, 0, 0, 0, 0);
    chk_b("b_reset", 0, 0, 0, 0, 0);
    chk("c_reset.cycles", 32'(c_cycles), 0);

    // ---- A: halt after 10 run cycles, 4 drain cycles with retire high
    a_rst = 1'b0; a_start = 1'b1;
    @(negedge clk);
    chk_a("a_enter_run", 0, 0, 0, 0, 1);
    a_start = 1'b0; a_retire = 1'b1;
    repeat (9) @(negedge clk);
    chk_a("a_run9", 9, 9, 0, 0, 1);
    a_halt = 1'b1;
    @(negedge clk);
    chk_a("a_halt10", 10, 10, 0, 0, 1);
    a_halt = 1'b0;
    repeat (3) @(negedge clk);
    chk_a("a_drain3", 13, 13, 0, 0, 1);
    @(negedge clk);
    chk_a("a_done", 14, 14, 1, 0, 0);

    // ---- A: DONE ignores all inputs
    for (int i = 0; i < 50; i++) begin
      a_start  = 1'($urandom);
      a_retire = 1'($urandom);
      a_halt   = 1'($urandom);
      @(negedge clk);
      chk("a_frozen.cycles", a_cycles, 14);
      chk("a_frozen.instr",  a_instr,  14);
      chk("a_frozen.stat",   32'(a_stat), 1);
    end

    // ---- A: async reset mid-DRAIN, then a fresh run
    a_start = 1'b0; a_retire = 1'b0; a_halt = 1'b0;
    a_rst = 1'b1;
    @(negedge clk);
    a_rst = 1'b0; a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0; a_retire = 1'b1;
    repeat (3) @(negedge clk);
    a_halt = 1'b1;
    @(negedge clk);
    a_halt = 1'b0;
    @(negedge clk);
    chk_a("a_mid_drain", 5, 5, 0, 0, 1);
    #2 a_rst = 1'b1;
    #1 chk_a("a_async_rst", 0, 0, 0, 0, 0);
    @(negedge clk);
    a_rst = 1'b0; a_start = 1'b1; a_retire = 1'b0;
    @(negedge clk);
    chk_a("a_rerun_start", 0, 0, 0, 0, 1);
    a_start = 1'b0; a_retire = 1'b1;
    repeat (5) @(negedge clk);
    chk_a("a_rerun5", 5, 5, 0, 0, 1);

    // ---- B: watchdog, retire every other cycle, start held high
    b_rst = 1'b0; b_start = 1'b1;
    @(negedge clk);
    for (int i = 1; i <= 20; i++) begin
      b_retire = (i % 2 == 1);
      @(negedge clk);
      if (i == 19) chk_b("b_wd19", 10, 19, 0, 0, 1);
    end
    chk_b("b_wd_done", 10, 20, 1, 1, 0);
    @(negedge clk);
    chk_b("b_wd_hold", 10, 20, 1, 1, 0);

    // ---- B: start+halt together in IDLE, then halt on the watchdog cycle
    b_start = 1'b0; b_retire = 1'b0;
    b_rst = 1'b1;
    @(negedge clk);
    b_rst = 1'b0; b_start = 1'b1; b_halt = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      b_halt = (i == 20);
      @(negedge clk);
      if (i == 4) chk_b("b_idle_halt_ignored", 0, 4, 0, 0, 1);
    end
    chk_b("b_halt_wd", 0, 20, 1, 1, 0);
    b_halt = 1'b0;

    // ---- C: 4-bit counters saturate at 15
    c_rst = 1'b0; c_start = 1'b1;
    @(negedge clk);
    c_start = 1'b0; c_retire = 1'b1;
    repeat (15) @(negedge clk);
    chk("c_at15.cycles", 32'(c_cycles), 15);
    chk("c_at15.instr",  32'(c_instr),  15);
    repeat (5) @(negedge clk);
    chk("c_sat.cycles",  32'(c_cycles), 15);
    chk("c_sat.instr",   32'(c_instr),  15);
    chk("c_sat.running", 32'(c_running), 1);
    chk("c_sat.timeout", 32'(c_timeout), 0);
    chk("c_sat.stat",    32'(c_stat), 0);
    c_retire = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
